bram_arbiter: RTL and testbench
===============================

Name: bram_arbiter

Overview:
- Shares one single-port block RAM between P_NREQ requesters, e.g. instruction fetch and load/store in the CPU.
- Performs round-robin arbitration and drives the RAM en/we/addr/wdata pins.
- The RAM has registered read data, so each response is routed back one cycle after the grant, tagged to the winning requester.
- Sits between the core's memory ports and the RAM instance.

Parameters:
- P_NREQ, 2, number of requesters (2..8).
- P_WIDTH, 32, data width; must match the RAM.
- P_SIZE, 256, RAM depth in words; address width AW = $clog2(P_SIZE).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req  input  P_NREQ  per-requester access request
- reqWe  input  P_NREQ  per-requester write enable, qualified by req
- reqAddr  input  P_NREQ*AW  packed addresses; requester i occupies slice [i*AW +: AW]
- reqData  input  P_NREQ*P_WIDTH  packed write data
- gnt  output  P_NREQ  one-hot grant, combinational, same cycle as req
- rspValid  output  P_NREQ  one-hot; response for the access granted in the previous cycle
- rspData  output  P_WIDTH  read data, shared by all requesters, valid with rspValid on a read
- ramEn  output  1  RAM enable
- ramWe  output  1  RAM write enable
- ramAddr  output  AW  RAM address
- ramWData  output  P_WIDTH  RAM write data
- ramRData  input  P_WIDTH  RAM registered read data

Behaviour:
- Reset is asynchronous and active-low.
  - While rst_n=0: gnt=0, ramEn=0, ramWe=0, rspValid=0, and the priority pointer last=P_NREQ-1 so requester 0 wins first.
  - ramAddr and ramWData are don't-care while ramEn=0 and are driven 0.
- Arbitration is combinational each cycle.
  - Search starts at (last+1) mod P_NREQ and wraps; the first requester with req=1 wins.
  - Exactly one gnt bit is set when any req is set; gnt=0 when none is set.
- RAM drive: ramEn=|gnt.
  - ramWe, ramAddr and ramWData are taken from the winner's slices.
  - When no requester wins, ramWe=0.
- The pointer updates on the clock edge only when a grant occurs: last<=winner index. Otherwise it holds.
- A requester holding req=1 is served at least once every P_NREQ cycles; there is no starvation.
- Handshake:
  - The access is accepted in the cycle where req&gnt.
  - The requester may change its request fields or deassert req on the next cycle.
  - An ungranted requester must hold req and its fields stable until granted.
- Response pipeline, a single stage:
  - rspValid[i]<=gnt[i] on every edge.
  - rspData=ramRData combinationally; it is meaningful only when the registered grant was a read.
  - A write also produces rspValid one cycle later as an acknowledgement; rspData is undefined for writes because the RAM holds its old read data.
- Throughput is one access per cycle and read latency is exactly 1 cycle from grant.
- Back-to-back grants to the same requester are allowed if it is the only requester.
- There is no response backpressure; requesters must accept rspValid unconditionally.
- Reset mid-operation: an in-flight response is dropped (rspValid forced to 0) and the pointer returns to P_NREQ-1. RAM contents are unaffected by the arbiter.
- Read-after-write to the same address from different requesters in consecutive cycles returns the new data, because the write completes in the RAM at the edge before the read grant.

Decomposition:
- Package bram_arb_pkg holds:
  - MAX_NREQ=8 constant.
  - Function onehot2idx(onehot) -> $clog2(MAX_NREQ) bits.
- Sub-module rr_arbiter (parameter P_N): inputs clk, rst_n, req; output one-hot gnt.
  - It owns the last pointer and the rotate-search.
  - bram_arbiter adds the muxing and the response stage.

Test Plan:
- Single requester 0 reads addr 0x10, with the RAM preloaded 0x10=0xDEADBEEF -> gnt=01 in cycle 0; rspValid=01 and rspData=0xDEADBEEF in cycle 1.
- Both requesters hold req continuously, reading addrs 0x1/0x2 -> grants alternate 01,10,01,10 starting with 01 after reset; each rspValid follows its grant by 1 cycle.
- Requester 1 writes 0x5=0xA5A5A5A5 in cycle n and requester 0 reads 0x5 in cycle n+1 -> rspData=0xA5A5A5A5 at cycle n+2 with rspValid=01.
- No requests for 4 cycles -> ramEn=0, gnt=0, rspValid=0; the pointer holds, and the next request from requester 1 after last=1 is still granted immediately.
- Assert rst_n=0 in the cycle after a read grant -> rspValid=0 immediately (asynchronous); after release, requester 0 wins a simultaneous 11 request.
- P_NREQ=4 with all four requesting for 8 cycles -> grant order 0,1,2,3,0,1,2,3 and each gnt one-hot.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared constants and helpers for the block-RAM arbiter.
package bram_arb_pkg;

   localparam int unsigned MAX_NREQ = 8;
   localparam int unsigned IDX_W    = $clog2(MAX_NREQ);

   function automatic logic [IDX_W-1:0] onehot2idx(input logic [MAX_NREQ-1:0] onehot);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < MAX_NREQ; i++) begin
         if (onehot[i]) idx = idx | IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner and wraps.
module rr_arbiter
   import bram_arb_pkg::*;
#(
   parameter int unsigned P_N = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [P_N-1:0] req,
   output logic [P_N-1:0] gnt
);

   localparam int unsigned IW = (P_N > 1) ? $clog2(P_N) : 1;

   logic [IW-1:0] last_q;
   logic [IW-1:0] last_d;
   logic          found;
   int unsigned   j;

   // Rotating priority search; nothing is granted while in reset.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      j     = 0;
      if (rst_n) begin
         for (int unsigned k = 1; k <= P_N; k++) begin
            j = (32'(last_q) + k) % P_N;
            if (!found && req[IW'(j)]) begin
               gnt[IW'(j)] = 1'b1;
               found       = 1'b1;
            end
         end
      end
   end

   always_comb begin
      last_d = last_q;
      if (|gnt) last_d = IW'(onehot2idx(MAX_NREQ'(gnt)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= IW'(P_N - 1);
      else        last_q <= last_d;
   end

endmodule

// File: rtl/bram_arbiter.sv
// Shares a single-port registered-output block RAM between P_NREQ requesters.
module bram_arbiter
   import bram_arb_pkg::*;
#(
   parameter int unsigned P_NREQ  = 2,
   parameter int unsigned P_WIDTH = 32,
   parameter int unsigned P_SIZE  = 256
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [P_NREQ-1:0]             req,
   input  logic [P_NREQ-1:0]             reqWe,
   input  logic [P_NREQ*$clog2(P_SIZE)-1:0] reqAddr,
   input  logic [P_NREQ*P_WIDTH-1:0]     reqData,
   output logic [P_NREQ-1:0]             gnt,
   output logic [P_NREQ-1:0]             rspValid,
   output logic [P_WIDTH-1:0]            rspData,
   output logic                          ramEn,
   output logic                          ramWe,
   output logic [$clog2(P_SIZE)-1:0]     ramAddr,
   output logic [P_WIDTH-1:0]            ramWData,
   input  logic [P_WIDTH-1:0]            ramRData
);

   localparam int unsigned AW = $clog2(P_SIZE);

   logic [P_NREQ-1:0]  gnt_w;
   logic [P_NREQ-1:0]  rsp_valid_q;
   logic               ram_we_c;
   logic [AW-1:0]      ram_addr_c;
   logic [P_WIDTH-1:0] ram_wdata_c;

   rr_arbiter #(.P_N(P_NREQ)) u_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .gnt   (gnt_w)
   );

   // Steer the winner's fields onto the RAM pins; idle drives zeros.
   always_comb begin
      ram_we_c    = 1'b0;
      ram_addr_c  = '0;
      ram_wdata_c = '0;
      for (int unsigned i = 0; i < P_NREQ; i++) begin
         if (gnt_w[i]) begin
            ram_we_c    = reqWe[i];
            ram_addr_c  = reqAddr[i*AW +: AW];
            ram_wdata_c = reqData[i*P_WIDTH +: P_WIDTH];
         end
      end
   end

   // Response tag tracks the RAM's one-cycle read latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rsp_valid_q <= '0;
      else        rsp_valid_q <= gnt_w;
   end

   assign gnt      = gnt_w;
   assign ramEn    = |gnt_w;
   assign ramWe    = ram_we_c;
   assign ramAddr  = ram_addr_c;
   assign ramWData = ram_wdata_c;
   assign rspValid = rsp_valid_q;
   assign rspData  = ramRData;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural registered-output RAM.
module tb_bram_arbiter;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    req, reqWe, gnt, rspValid;
   logic [2*AW-1:0] reqAddr;
   logic [2*DW-1:0] reqData;
   logic [DW-1:0] rspData, ramWData, ramRData;
   logic          ramEn, ramWe;
   logic [AW-1:0] ramAddr;

   logic [3:0]      req4, gnt4, rsp4;
   logic [DW-1:0]   rsp_data4, ram_wdata4;
   logic            ram_en4, ram_we4;
   logic [AW-1:0]   ram_addr4;

   logic [DW-1:0] mem [256];
   logic          pl_en;
   logic [AW-1:0] pl_addr;
   logic [DW-1:0] pl_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bram_arbiter #(.P_NREQ(2), .P_WIDTH(DW), .P_SIZE(256)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .reqWe(reqWe), .reqAddr(reqAddr),
      .reqData(reqData), .gnt(gnt), .rspValid(rspValid), .rspData(rspData),
      .ramEn(ramEn), .ramWe(ramWe), .ramAddr(ramAddr), .ramWData(ramWData),
      .ramRData(ramRData)
   );

   bram_arbiter #(.P_NREQ(4), .P_WIDTH(DW), .P_SIZE(256)) dut4 (
      .clk(clk), .rst_n(rst_n), .req(req4), .reqWe(4'b0000), .reqAddr({4*AW{1'b0}}),
      .reqData({4*DW{1'b0}}), .gnt(gnt4), .rspValid(rsp4), .rspData(rsp_data4),
      .ramEn(ram_en4), .ramWe(ram_we4), .ramAddr(ram_addr4), .ramWData(ram_wdata4),
      .ramRData(32'h0)
   );

   // RAM model: registered read, read data held across writes; backdoor preload.
   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (ramEn) begin
         if (ramWe) mem[ramAddr] <= ramWData;
         else       ramRData     <= mem[ramAddr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   logic [1:0] exp_g [4];
   logic [3:0] exp4  [8];

   initial begin
      rst_n = 1'b0; req = 2'b11; reqWe = '0; reqAddr = '0; reqData = '0;
      req4 = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      #2;
      preload(8'h10, 32'hDEADBEEF);
      preload(8'h01, 32'h11111111);
      preload(8'h02, 32'h22222222);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_ramEn", 32'(ramEn), 32'h0);
      chk("rst_ramWe", 32'(ramWe), 32'h0);
      chk("rst_rspValid", 32'(rspValid), 32'h0);
      chk("rst_ramAddr", 32'(ramAddr), 32'h0);
      rst_n = 1'b1;

      // Single read by requester 0
      req = 2'b01; reqAddr = {8'h00, 8'h10};
      #1;
      chk("rd_gnt", 32'(gnt), 32'h1);
      chk("rd_ramEn", 32'(ramEn), 32'h1);
      chk("rd_ramAddr", 32'(ramAddr), 32'h10);
      tick();
      chk("rd_rspValid", 32'(rspValid), 32'h1);
      chk("rd_rspData", rspData, 32'hDEADBEEF);
      req = 2'b00;

      // Both requesting continuously alternate from requester 0
      do_reset();
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      req = 2'b11; reqAddr = {8'h02, 8'h01};
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("alt_gnt%0d", c), 32'(gnt), 32'(exp_g[c]));
         tick();
         chk($sformatf("alt_rsp%0d", c), 32'(rspValid), 32'(exp_g[c]));
         chk($sformatf("alt_data%0d", c), rspData,
             (exp_g[c] == 2'b01) ? 32'h11111111 : 32'h22222222);
      end
      req = 2'b00;

      // Write by 1 then read-after-write by 0
      req = 2'b10; reqWe = 2'b10; reqAddr = {8'h05, 8'h00};
      reqData = {32'hA5A5A5A5, 32'h0};
      #1;
      chk("wr_gnt", 32'(gnt), 32'h2);
      chk("wr_ramWe", 32'(ramWe), 32'h1);
      chk("wr_ramAddr", 32'(ramAddr), 32'h5);
      chk("wr_ramWData", ramWData, 32'hA5A5A5A5);
      tick();
      chk("wr_ack", 32'(rspValid), 32'h2);
      req = 2'b01; reqWe = 2'b00; reqAddr = {8'h00, 8'h05};
      #1;
      chk("raw_gnt", 32'(gnt), 32'h1);
      chk("raw_ramWe", 32'(ramWe), 32'h0);
      tick();
      chk("raw_rsp", 32'(rspValid), 32'h1);
      chk("raw_data", rspData, 32'hA5A5A5A5);

      // Idle: pointer holds at 0 so a 11 request goes to requester 1
      req = 2'b00;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("idle_gnt%0d", c), 32'(gnt), 32'h0);
         chk($sformatf("idle_ramEn%0d", c), 32'(ramEn), 32'h0);
         chk($sformatf("idle_ramWe%0d", c), 32'(ramWe), 32'h0);
         tick();
         chk($sformatf("idle_rsp%0d", c), 32'(rspValid), 32'h0);
      end
      req = 2'b11; reqAddr = {8'h02, 8'h01};
      #1;
      chk("hold_gnt", 32'(gnt), 32'h2);
      tick();
      req = 2'b10;
      #1;
      chk("solo1_gnt", 32'(gnt), 32'h2);
      tick();
      chk("solo1_rsp", 32'(rspValid), 32'h2);
      req = 2'b00;

      // Reset during the response cycle drops the response
      req = 2'b01; reqAddr = {8'h00, 8'h10};
      #1;
      chk("prerst_gnt", 32'(gnt), 32'h1);
      tick();
      chk("prerst_rsp", 32'(rspValid), 32'h1);
      req = 2'b00;
      rst_n = 1'b0;
      #1;
      chk("async_rsp", 32'(rspValid), 32'h0);
      tick();
      rst_n = 1'b1;
      req = 2'b11;
      #1;
      chk("postrst_gnt", 32'(gnt), 32'h1);
      tick();
      req = 2'b00;

      // Four requesters rotate 0,1,2,3 from reset
      do_reset();
      exp4[0] = 4'h1; exp4[1] = 4'h2; exp4[2] = 4'h4; exp4[3] = 4'h8;
      exp4[4] = 4'h1; exp4[5] = 4'h2; exp4[6] = 4'h4; exp4[7] = 4'h8;
      req4 = 4'hF;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk($sformatf("rr4_gnt%0d", c), 32'(gnt4), 32'(exp4[c]));
         chk($sformatf("rr4_onehot%0d", c), 32'($onehot(gnt4)), 32'h1);
         tick();
         chk($sformatf("rr4_rsp%0d", c), 32'(rsp4), 32'(exp4[c]));
      end
      req4 = 4'h0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
